my9262_rx_monitor: RTL and testbench
====================================

// Module: my9262_rx_monitor
// PURPOSE
//  Receive end of the MY9262 serial link: samples Dclk/Di/Lat/Gck pins and rebuilds the
//  16-bit words the LED-driver transmitter shifts out. Words go into a small FIFO that the
//  Nios host reads over an Avalon-MM slave. Used as a loopback checker and readback path.
// PARAMETERS
//  DATA_W      16  bits per latched word, MSB first on Di
//  FIFO_DEPTH   8  captured-word FIFO entries (power of 2)
//  SYNC_STAGES  2  synchroniser flops on each pin input (>=2)
// PORTS
//  csi_clk          in   1   system clock; all logic on its rising edge
//  rsi_reset_n      in   1   synchronous, active-low reset
//  avs_address      in   2   register select: 0 DATA, 1 STATUS, 2 GCKCNT, 3 CTRL
//  avs_read         in   1   Avalon read strobe
//  avs_readdata     out  32  read data; valid one cycle after avs_read (readLatency=1)
//  avs_write        in   1   Avalon write strobe
//  avs_writedata    in   32  write data
//  coe_my9262_Dclk  in   1   serial clock pin (asynchronous to csi_clk)
//  coe_my9262_Di    in   1   serial data pin
//  coe_my9262_Lat   in   1   latch pin
//  coe_my9262_Gck   in   1   grey-scale clock pin
//  ins_irq          out  1   level interrupt: CTRL.irq_en & FIFO not empty (registered)
// BEHAVIOUR
//  Reset: avs_readdata=0, ins_irq=0, FIFO empty, shift reg/bit_cnt/GCKCNT=0, stickies=0,
//   CTRL=0x1 (enable=1, irq_en=0).
//  Inputs: each pin passes SYNC_STAGES flops plus one edge-detect flop. Link requires
//   Dclk/Lat/Gck high and low times >= SYNC_STAGES+1 csi_clk periods. Slower edges must
//   not be missed; faster ones are out of spec.
//  Dclk rise (enable=1): shift_reg <= {shift_reg[DATA_W-2:0], di_s}. di_s is sampled in
//   the same synchronised cycle. bit_cnt++ (5 bits, saturates at 31).
//  Lat rise (enable=1): if bit_cnt>=DATA_W, push shift_reg (last DATA_W bits) into the FIFO.
//   If bit_cnt<DATA_W, set STATUS.short and push nothing. bit_cnt<=0 in both cases.
//   Lat fall: no action.
//  Dclk rise and Lat rise in the same cycle: the shift is applied first, so the pushed word
//   includes the new bit.
//  Push while FIFO full: word dropped, STATUS.ovf set.
//  Push and pop in the same cycle while full: both happen, level unchanged, no ovf.
//  Gck rise (enable=1): GCKCNT++, 32-bit, wraps 0xFFFFFFFF->0.
//  enable=0: all pin edges ignored, bit_cnt forced to 0, FIFO and counters hold.
//  Read DATA (addr 0): returns {16'b0, fifo_head} and pops one entry. On empty returns 0,
//   no pop, no error.
//  Read STATUS (addr 1): [0] empty, [1] full, [2] ovf, [3] short, [7:4] 0,
//   [11:8] level (0..FIFO_DEPTH), rest 0.
//  Read GCKCNT (addr 2): live count. Read CTRL (addr 3): {30'b0, irq_en, enable}.
//  Write CTRL (addr 3): bit0 enable, bit1 irq_en. Bit2=1 clears ovf/short and GCKCNT.
//   Bit3=1 flushes the FIFO and clears bit_cnt. Bits 2 and 3 are self-clearing strobes.
//   A push in the same cycle as a flush is discarded.
//  Writes to addresses 0..2 are ignored. avs_read and avs_write asserted together: both
//   are served.
//  Reset asserted mid-frame: partial shift and bit_cnt discarded. After release, no word
//   is produced until a full frame followed by Lat is received.
// STRUCTURE
//  Package my9262_pkg: DATA_W default, register address localparams (ADDR_DATA/STATUS/
//   GCKCNT/CTRL), STATUS and CTRL bit-position constants. Shared with the transmitter side.
//  Sub-module my9262_rx_fifo: synchronous show-ahead FIFO (push/pop/flush, full/empty/level).
//  Top level holds the synchronisers, edge detectors, shifter, bit counter, GCK counter
//   and the Avalon register file.
// TESTING
//  1 Shift 0xA5C3 MSB-first (16 Dclk) then Lat -> STATUS level=1; DATA read = 0x0000A5C3.
//  2 Shift 20 bits 0xF_1234 then Lat -> DATA = 0x1234; 10 bits then Lat -> short=1,
//    level unchanged.
//  3 Send 9 frames with no reads (depth 8) -> full=1, ovf=1; eight reads return frames
//    1..8 in order.
//  4 FIFO full, Lat push in the same cycle as a DATA read -> level stays 8, ovf stays 0.
//  5 Toggle Gck 1000 times -> GCKCNT=1000; write CTRL=0x5 -> GCKCNT=0, stickies clear.
//  6 Set irq_en, send one frame -> ins_irq=1; pop -> ins_irq=0. Reset mid-frame after
//    8 bits, then send 0x00FF -> single word 0x00FF.

Source files
------------

// File: rtl/my9262_pkg.sv
// Shared MY9262 link definitions: word width, Avalon register map and bit positions.
// Used by both the receive monitor and the transmitter side.
package my9262_pkg;

    localparam int unsigned DATA_W = 16;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_GCKCNT = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int unsigned ST_EMPTY     = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_SHORT     = 3;
    localparam int unsigned ST_LEVEL_LSB = 8;
    localparam int unsigned ST_LEVEL_W   = 4;

    localparam int unsigned CTRL_ENABLE = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;
    localparam int unsigned CTRL_CLEAR  = 2;
    localparam int unsigned CTRL_FLUSH  = 3;

endpackage

// File: rtl/my9262_rx_monitor_if.sv
// Avalon-MM slave bus of the MY9262 receive monitor (readLatency = 1).
interface my9262_rx_monitor_if;

    logic [1:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/my9262_rx_fifo.sv
// Synchronous show-ahead FIFO for captured words; head is valid whenever not empty.
// A push while full is accepted only when a pop happens in the same cycle.
module my9262_rx_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop) & ~flush;

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/my9262_rx_monitor.sv
// MY9262 serial link receiver: synchronises the pins, rebuilds latched words into a FIFO
// and exposes FIFO, status, GCK count and control through an Avalon-MM slave.
module my9262_rx_monitor
    import my9262_pkg::*;
#(
    parameter int unsigned DATA_W      = my9262_pkg::DATA_W,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      csi_clk,
    input  logic                      rsi_reset_n,
    my9262_rx_monitor_if.slave        avs,
    input  logic                      coe_my9262_Dclk,
    input  logic                      coe_my9262_Di,
    input  logic                      coe_my9262_Lat,
    input  logic                      coe_my9262_Gck,
    output logic                      ins_irq
);

    // Pin vector order: {Gck, Lat, Di, Dclk}
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] edge_q, pin_s, rise;

    logic [DATA_W-1:0] shift_q, shift_nxt;
    logic [4:0]        bit_cnt, cnt_nxt;
    logic [31:0]       gck_cnt;
    logic              ovf_q, short_q, enable_q, irq_en_q, irq_q;
    logic [31:0]       readdata_q, rd_mux;

    logic dclk_rise, lat_rise, gck_rise, push_req, short_evt;
    logic rd_data, wr_ctrl, clear, flush, pop;

    logic [DATA_W-1:0]          fifo_head;
    logic                       fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                       unused_bits;

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            edge_q <= '0;
        end else begin
            sync_q[0] <= {coe_my9262_Gck, coe_my9262_Lat, coe_my9262_Di, coe_my9262_Dclk};
            for (int unsigned i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pin_s     = sync_q[SYNC_STAGES-1];
    assign rise      = pin_s & ~edge_q;
    assign dclk_rise = rise[0] & enable_q;
    assign lat_rise  = rise[2] & enable_q;
    assign gck_rise  = rise[3] & enable_q;

    // The shift and count of a coincident Dclk rise are folded in before the Lat decision
    assign shift_nxt = dclk_rise ? {shift_q[DATA_W-2:0], pin_s[1]} : shift_q;
    assign cnt_nxt   = (dclk_rise && bit_cnt != 5'd31) ? bit_cnt + 5'd1 : bit_cnt;
    assign push_req  = lat_rise && (32'(cnt_nxt) >= DATA_W);
    assign short_evt = lat_rise && !push_req;

    assign rd_data = avs.avs_read && (avs.avs_address == ADDR_DATA);
    assign wr_ctrl = avs.avs_write && (avs.avs_address == ADDR_CTRL);
    assign clear   = wr_ctrl && avs.avs_writedata[CTRL_CLEAR];
    assign flush   = wr_ctrl && avs.avs_writedata[CTRL_FLUSH];
    assign pop     = rd_data && !fifo_empty;

    my9262_rx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (csi_clk),
        .rst_n     (rsi_reset_n),
        .push      (push_req),
        .push_data (shift_nxt),
        .pop       (pop),
        .flush     (flush),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            ADDR_DATA:   if (!fifo_empty) rd_mux[DATA_W-1:0] = fifo_head;
            ADDR_STATUS: begin
                rd_mux[ST_EMPTY] = fifo_empty;
                rd_mux[ST_FULL]  = fifo_full;
                rd_mux[ST_OVF]   = ovf_q;
                rd_mux[ST_SHORT] = short_q;
                rd_mux[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(fifo_level);
            end
            ADDR_GCKCNT: rd_mux = gck_cnt;
            default: begin
                rd_mux[CTRL_ENABLE] = enable_q;
                rd_mux[CTRL_IRQ_EN] = irq_en_q;
            end
        endcase
    end

    always_ff @(posedge csi_clk) begin
        if (!rsi_reset_n) begin
            shift_q    <= '0;
            bit_cnt    <= '0;
            gck_cnt    <= '0;
            ovf_q      <= 1'b0;
            short_q    <= 1'b0;
            enable_q   <= 1'b1;
            irq_en_q   <= 1'b0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            shift_q <= shift_nxt;
            bit_cnt <= (!enable_q || flush || lat_rise) ? 5'd0 : cnt_nxt;

            if (clear)
                gck_cnt <= '0;
            else if (gck_rise)
                gck_cnt <= gck_cnt + 32'd1;

            if (clear) begin
                ovf_q   <= 1'b0;
                short_q <= 1'b0;
            end else begin
                if (push_req && fifo_full && !pop && !flush)
                    ovf_q <= 1'b1;
                if (short_evt)
                    short_q <= 1'b1;
            end

            if (wr_ctrl) begin
                enable_q <= avs.avs_writedata[CTRL_ENABLE];
                irq_en_q <= avs.avs_writedata[CTRL_IRQ_EN];
            end

            if (avs.avs_read)
                readdata_q <= rd_mux;

            irq_q <= irq_en_q && !fifo_empty;
        end
    end

    assign avs.avs_readdata = readdata_q;
    assign ins_irq          = irq_q;
    assign unused_bits      = ^{avs.avs_writedata[31:4], rise[1]};

endmodule

// File: tb/tb_my9262_rx_monitor.sv
// Self-checking bench for my9262_rx_monitor: frames driven on the pins push expected words
// into a scoreboard queue, which is popped and compared on every DATA read.
module tb_my9262_rx_monitor;
    import my9262_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dclk = 1'b0, di = 1'b0, lat = 1'b0, gck = 1'b0;
    logic irq;

    my9262_rx_monitor_if avs ();

    my9262_rx_monitor #(
        .DATA_W      (16),
        .FIFO_DEPTH  (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .csi_clk         (clk),
        .rsi_reset_n     (rst_n),
        .avs             (avs.master),
        .coe_my9262_Dclk (dclk),
        .coe_my9262_Di   (di),
        .coe_my9262_Lat  (lat),
        .coe_my9262_Gck  (gck),
        .ins_irq         (irq)
    );

    always #5 clk = ~clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    logic [15:0] exp_q [$];
    logic        m_ovf = 1'b0, m_short = 1'b0, m_en = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        avs.avs_address   = addr;
        avs.avs_writedata = data;
        avs.avs_write     = 1'b1;
        wait_cyc(1);
        avs.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        avs.avs_address = addr;
        avs.avs_read    = 1'b1;
        wait_cyc(1);
        avs.avs_read    = 1'b0;
        data            = avs.avs_readdata;
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        int unsigned sz;
        sz = exp_q.size();
        s = '0;
        s[ST_EMPTY] = (sz == 0);
        s[ST_FULL]  = (sz == DEPTH);
        s[ST_OVF]   = m_ovf;
        s[ST_SHORT] = m_short;
        s[11:8]     = 4'(sz);
        return s;
    endfunction

    task automatic check_status(input string tag);
        logic [31:0] d;
        bus_read(ADDR_STATUS, d);
        check(tag, d, exp_status());
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] d, e;
        e = '0;
        if (exp_q.size() != 0) e = {16'b0, exp_q.pop_front()};
        bus_read(ADDR_DATA, d);
        check(tag, d, e);
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            di   = val[i];
            dclk = 1'b0;
            wait_cyc(4);
            dclk = 1'b1;
            wait_cyc(4);
        end
        dclk = 1'b0;
        di   = 1'b0;
        wait_cyc(4);
    endtask

    task automatic pulse_lat();
        lat = 1'b1;
        wait_cyc(4);
        lat = 1'b0;
        wait_cyc(4);
    endtask

    task automatic send_frame(input logic [31:0] val, input int n);
        send_bits(val, n);
        pulse_lat();
        if (m_en) begin
            if (n >= 16) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(val[15:0]);
                else m_ovf = 1'b1;
            end else begin
                m_short = 1'b1;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        logic [31:0] d;
        check({tag, "_readdata"}, avs.avs_readdata, 32'h0);
        check({tag, "_irq"}, {31'b0, irq}, 32'h0);
        check_status({tag, "_status"});
        bus_read(ADDR_CTRL, d);
        check({tag, "_ctrl"}, d, 32'h1);
        bus_read(ADDR_GCKCNT, d);
        check({tag, "_gckcnt"}, d, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d, e;
        avs.avs_address   = '0;
        avs.avs_read      = 1'b0;
        avs.avs_write     = 1'b0;
        avs.avs_writedata = '0;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(2);
        check_reset_state("reset");

        // Basic frame, MSB first
        send_frame(32'hA5C3, 16);
        check_status("t1_status");
        pop_check("t1_data");

        // Over-long frame keeps last 16 bits; short frame pushes nothing
        send_frame(32'hF1234, 20);
        send_frame(32'h2AB, 10);
        check_status("t2_status_short");
        pop_check("t2_data");
        pop_check("empty_read");

        // Disabled link ignores frames
        bus_write(ADDR_CTRL, 32'h0);
        m_en = 1'b0;
        send_frame(32'h1111, 16);
        bus_write(ADDR_CTRL, 32'h1);
        m_en = 1'b1;
        check_status("disabled_status");

        // Overflow: nine frames into an eight-entry FIFO
        for (int i = 1; i <= 9; i++)
            send_frame(32'h1000 + 32'(i) * 32'h0111, 16);
        check_status("t3_full_ovf");
        for (int i = 1; i <= 8; i++)
            pop_check($sformatf("t3_data%0d", i));
        check_status("t3_drained");

        // GCK counter and sticky clear
        for (int i = 0; i < 1000; i++) begin
            gck = 1'b1;
            wait_cyc(3);
            gck = 1'b0;
            wait_cyc(3);
        end
        wait_cyc(4);
        bus_read(ADDR_GCKCNT, d);
        check("t5_gckcnt", d, 32'd1000);
        bus_write(ADDR_CTRL, 32'h5);
        m_ovf   = 1'b0;
        m_short = 1'b0;
        bus_read(ADDR_GCKCNT, d);
        check("t5_gck_clear", d, 32'h0);
        check_status("t5_stickies");

        // Full FIFO: push and DATA read land on the same clock
        for (int i = 0; i < 8; i++)
            send_frame(32'h3000 + 32'(i), 16);
        send_bits(32'hBEEF, 16);
        lat = 1'b1;
        wait_cyc(2);
        avs.avs_address = ADDR_DATA;
        avs.avs_read    = 1'b1;
        wait_cyc(1);
        avs.avs_read    = 1'b0;
        d = avs.avs_readdata;
        e = {16'b0, exp_q.pop_front()};
        exp_q.push_back(16'hBEEF);
        check("t4_pop_data", d, e);
        wait_cyc(3);
        lat = 1'b0;
        wait_cyc(4);
        check_status("t4_level8_no_ovf");
        for (int i = 0; i < 8; i++)
            pop_check($sformatf("t4_drain%0d", i));

        // Flush discards queued words
        send_frame(32'h4444, 16);
        send_frame(32'h5555, 16);
        bus_write(ADDR_CTRL, 32'h9);
        exp_q.delete();
        check_status("flush_status");
        pop_check("flush_empty_read");

        // Interrupt follows FIFO occupancy when enabled
        bus_write(ADDR_CTRL, 32'h3);
        send_frame(32'h6789, 16);
        check("t6_irq_set", {31'b0, irq}, 32'h1);
        pop_check("t6_irq_data");
        wait_cyc(2);
        check("t6_irq_clr", {31'b0, irq}, 32'h0);

        // Reset mid-frame drops the partial word
        send_bits(32'hAB, 8);
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        exp_q.delete();
        m_ovf   = 1'b0;
        m_short = 1'b0;
        wait_cyc(2);
        check_reset_state("midreset");
        send_frame(32'h00FF, 16);
        check_status("t6_single_word");
        pop_check("t6_data_00ff");
        check_status("t6_empty_after");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
